// File: rtl/seq_array_mult.sv
// rtl/seq_array_mult.sv - iterative shift-add multiplier, signed/unsigned, valid/ready on both sides
module seq_array_mult #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_step;

    // Magnitudes are W-bit unsigned, so the most negative operand maps to 2^(W-1).
    always_comb begin
        a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
        b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;
    end

    // The multiplier lives in the low half of the accumulator and shifts out LSB first.
    always_comb begin
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_step = {sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a_mag;
                    acc_d   = {{WIDTH{1'b0}}, b_mag};
                    neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    p_d     = neg_q ? -acc_step : acc_step;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign p         = p_q;

endmodule

// File: doc/seq_array_mult.md
# seq_array_mult

Parametrised, iterative shift-add multiplier: the multi-cycle, handshaked successor to the team's combinational 6-bit unsigned array multiplier. It adds a WIDTH parameter, a per-operation signed/unsigned mode, and valid/ready flow control on both sides. It sits between an operand producer and a result consumer that both speak valid/ready. It trades one result per WIDTH+2 cycles for a single W-bit adder instead of a full array.

## Interface
- WIDTH, 6, operand width in bits; legal range 2..32; product width is 2*WIDTH.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand bundle (a, b, signed_mode) valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  0 = unsigned operands; 1 = two's-complement operands.
- out_valid  output  1  p holds a completed product.
- out_ready  input  1  consumer accepts p.
- p  output  2*WIDTH  product; unsigned or two's-complement per the captured mode.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture operands and mode, then go to CALC.
- Operand capture:
  - Signed mode: magnitudes |a| and |b| are computed as W-bit unsigned values, so -2^(W-1) maps to 2^(W-1).
  - neg = a[W-1]^b[W-1] is captured.
  - Unsigned mode: operands are taken as-is, neg=0.
- CALC: radix-2 shift-add over exactly WIDTH iterations, LSB of multiplier first. An iteration counter of clog2(WIDTH+1) bits runs 0..WIDTH-1.
- Final CALC iteration:
  - p <= neg ? -(acc) : acc, full 2*WIDTH bits, no truncation.
  - Magnitude product is at most (2^W-1)^2, which fits 2W bits unsigned.
  - Signed products lie in [-(2^(W-1))(2^(W-1)-1), 2^(2W-2)], which fits 2W-bit two's complement.
  - State goes to DONE.
- DONE: out_valid=1 and p is held stable. On out_ready, go to IDLE.
- a, b, signed_mode and in_valid are ignored outside IDLE. Changes mid-operation do not affect the result.
- No overlap: a new operand cannot be accepted in the cycle out_valid&&out_ready fires. in_ready rises the following cycle.
- p retains the last product after handshake until the next result overwrites it.

## Timing
- Reset (async assert, synchronous-safe deassert assumed from top-level synchroniser):
  - state=IDLE, in_ready=1, out_valid=0, p=0.
  - Accumulator and counter cleared.
- Accept edge at cycle T. CALC occupies the edges T+1 .. T+WIDTH. out_valid rises after edge T+WIDTH, so operand-to-result latency is WIDTH cycles.
- out_valid stays high until the cycle with out_ready=1. out_valid falls and in_ready rises after that edge.
- Best-case throughput is one product per WIDTH+2 cycles, with out_ready held high.
- out_ready high before out_valid has no effect.
- Reset asserted in CALC or DONE aborts the operation: no out_valid, p=0, block returns to IDLE.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- WIDTH=6, unsigned, out_ready=1, five operations:
  - 0*4 -> 0
  - 13*1 -> 13
  - 9*3 -> 27
  - 60*15 -> 900
  - 63*63 -> 3969
  - Each result must have out_valid exactly 6 cycles after accept, and in_ready low during CALC and DONE.
- WIDTH=6, signed:
  - a=6'b111111 (-1), b=3 -> p=12'hFFD (-3)
  - a=6'b100000 (-32), b=6'b100000 -> p=1024
  - a=-32, b=31 -> p=-992 (12'hC20)
  - a=0, b=-5 -> p=0
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - p and out_valid must stay stable.
  - in_valid pulses in that window must be ignored (in_ready=0).
  - Release out_ready: one handshake, then in_ready=1 on the next cycle.
- Operand corruption: accept a=36, b=42 (unsigned), then change a, b and signed_mode every cycle during CALC -> p=1512.
- Reset mid-CALC: assert rst_n=0 at iteration 3 of 60*48.
  - Outputs must go to reset values immediately (asynchronously).
  - No out_valid may follow.
  - A subsequent 60*48 must yield 2880.
- WIDTH=16 instance:
  - 65535*65535 unsigned -> 32'hFFFE0001, latency 16.
  - Signed -32768*-32768 -> 32'h40000000.
